warp_scheduler: RTL and testbench
=================================

Name: warp_scheduler

Overview:
Per-cycle issue arbiter that sits directly downstream of the warp readiness checker. Consumes its ready_warps vector plus instruction-buffer occupancy and picks one warp per cycle, round-robin. Presents the pick through a valid/ready issue interface to the dispatch stage and pops the chosen warp's instruction buffer on handshake. Also masks the one-cycle scoreboard lag, so a just-issued warp is not re-picked on stale readiness.

Parameters:
NUM_WARPS, 4, number of warps arbitrated
WARP_ID_W, 2, width of warp index (clog2(NUM_WARPS))
BLOCK_CYCLES, 1, cycles a warp is ineligible after its issue (covers scoreboard update latency); must be >= 1
CNT_W, 16, width of performance counters

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ready_warps  input  NUM_WARPS  per-warp readiness from the readiness checker (1 = no thread hazard)
buf_valid  input  NUM_WARPS  per-warp instruction buffer holds a next instruction
launch_valid  input  1  pulse: activate warps in launch_mask
launch_mask  input  NUM_WARPS  warps to activate
retire_valid  input  1  pulse: deactivate warp retire_id
retire_id  input  WARP_ID_W  warp being retired
issue_valid  output  1  issue slot holds a selected warp
issue_ready  input  1  dispatch accepts the issue this cycle
issue_warp_id  output  WARP_ID_W  selected warp index
issue_grant  output  NUM_WARPS  one-hot of issue_warp_id, qualified by issue_valid
buf_pop  output  NUM_WARPS  one-hot pop to instruction buffer, asserted on handshake cycle only
active_warps  output  NUM_WARPS  current active mask
issue_count  output  CNT_W  saturating count of handshakes
stall_count  output  CNT_W  saturating count of cycles with active_warps != 0 and issue_valid = 0

Behaviour:
- Reset (async, rst_n low): issue_valid=0, issue_warp_id=0, active_warps=0, all cooldown counters=0, rr_ptr=NUM_WARPS-1 (so warp 0 has first priority), issue_count=0, stall_count=0. buf_pop and issue_grant are 0 as a consequence.
- Reset mid-operation discards any held issue. No handshake completes during reset.
- eligible[w] = active[w] & buf_valid[w] & ready_warps[w] & (cooldown[w]==0) & ~(issue_valid & issue_warp_id==w & ~handshake).
- Round-robin pick: first eligible warp scanning rr_ptr+1, rr_ptr+2, ... with wrap modulo NUM_WARPS.
- Two states.
  - IDLE (issue_valid=0): if any eligible warp exists, register the pick at the clock edge. issue_valid=1 next cycle (latency 1 from eligibility to valid).
  - HOLD (issue_valid=1): issue_warp_id stays stable until handshake (issue_valid & issue_ready). Valid is never withdrawn except on retire of the held warp.
- On handshake:
  - buf_pop[issue_warp_id]=1 combinationally that cycle.
  - rr_ptr <= issue_warp_id.
  - cooldown[issue_warp_id] <= BLOCK_CYCLES.
  - issue_count += 1, saturating at all-ones.
  - The same edge may load a new pick, excluding the warp just issued, giving back-to-back issue at one per cycle. With no other eligible warp, go to IDLE.
- Cooldown counters decrement by 1 per cycle while nonzero.
- Readiness is sampled only at selection. A held warp stays held even if ready_warps drops; dispatch owns that hazard.
- Active mask update: active <= (active & ~retire_onehot) | launch_mask_if_valid. Launch wins when the same warp is launched and retired in one cycle.
- Retire of the currently held warp with no simultaneous handshake drops issue_valid next cycle (state -> IDLE). No pop occurs. If a handshake coincides with that retire, the handshake completes normally.
- Retire of an inactive warp is a no-op.
- stall_count increments each cycle active_warps != 0 and issue_valid == 0, saturating.

Decomposition:
- Shared package sched_pkg holds: NUM_WARPS, WARP_ID_W, the warp_id_t typedef, and a state enum {IDLE, HOLD}.
- One natural sub-module: rr_arbiter (parameterised NUM_WARPS; inputs request vector and rr_ptr; outputs one-hot grant, index and any_grant), purely combinational.
- The top holds the registers, cooldown counters and perf counters.

Test Plan:
- Reset, launch_mask=4'b1111, all buf_valid/ready_warps=1, issue_ready=1 -> issue_valid rises 2 cycles after launch; warp ids 0,1,2,3,0,... one per cycle; buf_pop one-hot matches each issue.
- Only warp 2 eligible, BLOCK_CYCLES=1, issue_ready=1 -> issues of warp 2 separated by the cooldown gap; stall_count increments during the gaps.
- issue_ready=0 for 5 cycles while warp 1 is held, and ready_warps[1] drops -> issue_warp_id stays 1 and valid stays 1; on ready=1 exactly one buf_pop[1] pulse.
- Warp 3 held, retire_valid with retire_id=3, issue_ready=0 -> issue_valid=0 next cycle, no pop; active_warps[3]=0.
- Same cycle launch_valid with launch_mask=4'b0100 and retire_id=2 -> active_warps[2]=1.
- Force 2^CNT_W+3 handshakes (CNT_W reduced to 4 in bench) -> issue_count saturates at 4'hF. Assert rst_n low mid-HOLD -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/sched_pkg.sv
// Shared definitions for the warp issue scheduler: default sizing, the
// warp index type and the two-state issue FSM encoding.
package sched_pkg;

  localparam int NUM_WARPS = 4;
  localparam int WARP_ID_W = 2;

  typedef logic [WARP_ID_W-1:0] warp_id_t;

  // IDLE: issue slot empty. HOLD: issue slot presents a selected warp.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/warp_scheduler_rr_arbiter.sv
// Combinational round-robin picker: returns the first requesting warp found
// scanning upward from rr_ptr_i + 1, wrapping modulo NUM_WARPS.
module rr_arbiter #(
  parameter int NUM_WARPS = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_WARPS-1:0] req_i,
  input  logic [IDX_W-1:0]     rr_ptr_i,
  output logic [NUM_WARPS-1:0] grant_o,
  output logic [IDX_W-1:0]     idx_o,
  output logic                 any_o
);

  int               cand_s;
  logic [IDX_W-1:0] cand_idx_s;

  // Scan the NUM_WARPS candidates in priority order and keep the first hit.
  always_comb begin
    grant_o    = '0;
    idx_o      = '0;
    any_o      = 1'b0;
    cand_s     = 0;
    cand_idx_s = '0;
    for (int i = 1; i <= NUM_WARPS; i++) begin
      cand_s     = (int'(rr_ptr_i) + i) % NUM_WARPS;
      cand_idx_s = IDX_W'(cand_s);
      if (!any_o && req_i[cand_idx_s]) begin
        grant_o[cand_idx_s] = 1'b1;
        idx_o               = cand_idx_s;
        any_o               = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/warp_scheduler.sv
// Per-cycle warp issue arbiter. Picks one eligible warp round-robin, holds it
// on a valid/ready issue port, pops its instruction buffer on handshake and
// blocks the issued warp for BLOCK_CYCLES to hide the scoreboard update lag.
module warp_scheduler #(
  parameter int NUM_WARPS    = sched_pkg::NUM_WARPS,
  parameter int WARP_ID_W    = sched_pkg::WARP_ID_W,
  parameter int BLOCK_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_WARPS-1:0] ready_warps,
  input  logic [NUM_WARPS-1:0] buf_valid,
  input  logic                 launch_valid,
  input  logic [NUM_WARPS-1:0] launch_mask,
  input  logic                 retire_valid,
  input  logic [WARP_ID_W-1:0] retire_id,
  output logic                 issue_valid,
  input  logic                 issue_ready,
  output logic [WARP_ID_W-1:0] issue_warp_id,
  output logic [NUM_WARPS-1:0] issue_grant,
  output logic [NUM_WARPS-1:0] buf_pop,
  output logic [NUM_WARPS-1:0] active_warps,
  output logic [CNT_W-1:0]     issue_count,
  output logic [CNT_W-1:0]     stall_count
);

  import sched_pkg::*;

  // Cooldown counter must be able to hold BLOCK_CYCLES.
  localparam int CD_W = (BLOCK_CYCLES < 2) ? 1 : $clog2(BLOCK_CYCLES + 1);
  localparam logic [CD_W-1:0]      CD_LOAD  = CD_W'(BLOCK_CYCLES);
  localparam logic [NUM_WARPS-1:0] ONE_HOT0 = {{(NUM_WARPS-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]     CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Registers
  state_e                         state_q, state_d;
  logic [WARP_ID_W-1:0]           id_q, id_d;
  logic [WARP_ID_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic [NUM_WARPS-1:0]           active_q, active_d;
  logic [NUM_WARPS-1:0][CD_W-1:0] cd_q, cd_d;
  logic [CNT_W-1:0]               issue_count_q, issue_count_d;
  logic [CNT_W-1:0]               stall_count_q, stall_count_d;

  // Combinational helpers
  logic                 valid_s;
  logic                 hs_s;
  logic [NUM_WARPS-1:0] held_oh_s;
  logic [NUM_WARPS-1:0] retire_oh_s;
  logic                 retire_held_s;
  logic [NUM_WARPS-1:0] cd_zero_s;
  logic [NUM_WARPS-1:0] req_s;
  logic [NUM_WARPS-1:0] pick_grant_s;
  logic [WARP_ID_W-1:0] pick_idx_s;
  logic                 pick_any_s;

  assign valid_s       = (state_q == HOLD);
  assign hs_s          = valid_s & issue_ready;
  assign held_oh_s     = ONE_HOT0 << id_q;
  assign retire_oh_s   = retire_valid ? (ONE_HOT0 << retire_id) : '0;
  assign retire_held_s = valid_s & retire_valid & (retire_id == id_q);

  // Eligibility: the held warp is never a candidate, so a handshake edge
  // always moves on to a different warp.
  always_comb begin
    cd_zero_s = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      cd_zero_s[w] = (cd_q[w] == '0);
    end
    req_s = active_q & buf_valid & ready_warps & cd_zero_s
          & ~(valid_s ? held_oh_s : '0);
  end

  rr_arbiter #(
    .NUM_WARPS (NUM_WARPS),
    .IDX_W     (WARP_ID_W)
  ) u_rr_arbiter (
    .req_i    (req_s),
    .rr_ptr_i (rr_ptr_q),
    .grant_o  (pick_grant_s),
    .idx_o    (pick_idx_s),
    .any_o    (pick_any_s)
  );

  // Issue FSM: load a pick when idle or on handshake, hold otherwise,
  // and drop the slot if the held warp retires without being accepted.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_any_s) begin
          state_d = HOLD;
          id_d    = pick_idx_s;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (hs_s) begin
          rr_ptr_d = id_q;
          if (pick_any_s) begin
            state_d = HOLD;
            id_d    = pick_idx_s;
          end else begin
            state_d = IDLE;
          end
        end else if (retire_held_s) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Active mask: retire clears, launch sets, launch wins on collision.
  always_comb begin
    active_d = (active_q & ~retire_oh_s) | (launch_valid ? launch_mask : '0);
  end

  // Cooldown: reload on issue of that warp, otherwise count down to zero.
  always_comb begin
    cd_d = cd_q;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (hs_s && (id_q == WARP_ID_W'(w))) begin
        cd_d[w] = CD_LOAD;
      end else if (cd_q[w] != '0) begin
        cd_d[w] = cd_q[w] - {{(CD_W-1){1'b0}}, 1'b1};
      end else begin
        cd_d[w] = cd_q[w];
      end
    end
  end

  // Saturating performance counters.
  always_comb begin
    if (hs_s && (issue_count_q != {CNT_W{1'b1}})) begin
      issue_count_d = issue_count_q + CNT_ONE;
    end else begin
      issue_count_d = issue_count_q;
    end
    if ((|active_q) && !valid_s && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_ONE;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // State registers with asynchronous reset; warp 0 has first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      id_q          <= '0;
      rr_ptr_q      <= WARP_ID_W'(NUM_WARPS - 1);
      active_q      <= '0;
      cd_q          <= '0;
      issue_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      id_q          <= id_d;
      rr_ptr_q      <= rr_ptr_d;
      active_q      <= active_d;
      cd_q          <= cd_d;
      issue_count_q <= issue_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign issue_valid   = valid_s;
  assign issue_warp_id = id_q;
  assign issue_grant   = valid_s ? held_oh_s : '0;
  assign buf_pop       = hs_s ? held_oh_s : '0;
  assign active_warps  = active_q;
  assign issue_count   = issue_count_q;
  assign stall_count   = stall_count_q;

endmodule

// File: tb/tb_warp_scheduler.sv
// Directed, table-driven bench for warp_scheduler (CNT_W reduced to 4).
module tb_warp_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] ready_warps = 4'h0;
  logic [3:0] buf_valid = 4'h0;
  logic       launch_valid = 1'b0;
  logic [3:0] launch_mask = 4'h0;
  logic       retire_valid = 1'b0;
  logic [1:0] retire_id = 2'd0;
  logic       issue_valid;
  logic       issue_ready = 1'b0;
  logic [1:0] issue_warp_id;
  logic [3:0] issue_grant;
  logic [3:0] buf_pop;
  logic [3:0] active_warps;
  logic [3:0] issue_count;
  logic [3:0] stall_count;

  int checks = 0;
  int errors = 0;

  warp_scheduler #(
    .NUM_WARPS    (4),
    .WARP_ID_W    (2),
    .BLOCK_CYCLES (1),
    .CNT_W        (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ready_warps   (ready_warps),
    .buf_valid     (buf_valid),
    .launch_valid  (launch_valid),
    .launch_mask   (launch_mask),
    .retire_valid  (retire_valid),
    .retire_id     (retire_id),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_warp_id (issue_warp_id),
    .issue_grant   (issue_grant),
    .buf_pop       (buf_pop),
    .active_warps  (active_warps),
    .issue_count   (issue_count),
    .stall_count   (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rst_before;
    bit       lv;
    bit [3:0] lm;
    bit       rv;
    bit [1:0] rid;
    bit [3:0] rdy;
    bit [3:0] bufv;
    bit       ir;
    bit       ev;
    bit [1:0] eid;
    bit [3:0] epop;
    bit [3:0] eact;
    bit [3:0] eicnt;
    bit [3:0] estall;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit r, input bit lv, input bit [3:0] lm,
                              input bit rv, input bit [1:0] rid, input bit [3:0] rdy,
                              input bit [3:0] bufv, input bit ir, input bit ev,
                              input bit [1:0] eid, input bit [3:0] epop,
                              input bit [3:0] eact, input bit [3:0] eicnt,
                              input bit [3:0] estall);
    vec_t v;
    v = '{r, lv, lm, rv, rid, rdy, bufv, ir, ev, eid, epop, eact, eicnt, estall};
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Assert reset asynchronously, check the reset state, release after an edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, " rst valid"},  int'(issue_valid), 0);
    chk({tag, " rst id"},     int'(issue_warp_id), 0);
    chk({tag, " rst grant"},  int'(issue_grant), 0);
    chk({tag, " rst pop"},    int'(buf_pop), 0);
    chk({tag, " rst active"}, int'(active_warps), 0);
    chk({tag, " rst icnt"},   int'(issue_count), 0);
    chk({tag, " rst stall"},  int'(stall_count), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t v;
    int   exp_id;
    int   exp_cnt;

    // A: all warps eligible, launch -> valid 2 cycles later, ids 0,1,2,3,0,1
    add(1, 1, 4'hF, 0, 2'd0, 4'hF, 4'hF, 1,  0, 2'd0, 4'h0, 4'h0, 4'd0, 4'd0);
    add(0, 0, 4'h0, 0, 2'd0, 4'hF, 4'hF, 1,  0, 2'd0, 4'h0, 4'hF, 4'd0, 4'd0);
    add(0, 0, 4'h0, 0, 2'd0, 4'hF, 4'hF, 1,  1, 2'd0, 4'h1, 4'hF, 4'd0, 4'd1);
    add(0, 0, 4'h0, 0, 2'd0, 4'hF, 4'hF, 1,  1, 2'd1, 4'h2, 4'hF, 4'd1, 4'd1);
    add(0, 0, 4'h0, 0, 2'd0, 4'hF, 4'hF, 1,  1, 2'd2, 4'h4, 4'hF, 4'd2, 4'd1);
    add(0, 0, 4'h0, 0, 2'd0, 4'hF, 4'hF, 1,  1, 2'd3, 4'h8, 4'hF, 4'd3, 4'd1);
    add(0, 0, 4'h0, 0, 2'd0, 4'hF, 4'hF, 1,  1, 2'd0, 4'h1, 4'hF, 4'd4, 4'd1);
    add(0, 0, 4'h0, 0, 2'd0, 4'hF, 4'hF, 1,  1, 2'd1, 4'h2, 4'hF, 4'd5, 4'd1);
    // B: only warp 2 active, cooldown gaps count as stall cycles
    add(1, 1, 4'h4, 0, 2'd0, 4'hF, 4'hF, 1,  0, 2'd0, 4'h0, 4'h0, 4'd0, 4'd0);
    add(0, 0, 4'h0, 0, 2'd0, 4'hF, 4'hF, 1,  0, 2'd0, 4'h0, 4'h4, 4'd0, 4'd0);
    add(0, 0, 4'h0, 0, 2'd0, 4'hF, 4'hF, 1,  1, 2'd2, 4'h4, 4'h4, 4'd0, 4'd1);
    add(0, 0, 4'h0, 0, 2'd0, 4'hF, 4'hF, 1,  0, 2'd0, 4'h0, 4'h4, 4'd1, 4'd1);
    add(0, 0, 4'h0, 0, 2'd0, 4'hF, 4'hF, 1,  0, 2'd0, 4'h0, 4'h4, 4'd1, 4'd2);
    add(0, 0, 4'h0, 0, 2'd0, 4'hF, 4'hF, 1,  1, 2'd2, 4'h4, 4'h4, 4'd1, 4'd3);
    add(0, 0, 4'h0, 0, 2'd0, 4'hF, 4'hF, 1,  0, 2'd0, 4'h0, 4'h4, 4'd2, 4'd3);
    add(0, 0, 4'h0, 0, 2'd0, 4'hF, 4'hF, 1,  0, 2'd0, 4'h0, 4'h4, 4'd2, 4'd4);
    add(0, 0, 4'h0, 0, 2'd0, 4'hF, 4'hF, 1,  1, 2'd2, 4'h4, 4'h4, 4'd2, 4'd5);
    // C: warp 1 held 5 cycles with issue_ready=0 and readiness dropped
    add(1, 1, 4'h2, 0, 2'd0, 4'hF, 4'hF, 0,  0, 2'd0, 4'h0, 4'h0, 4'd0, 4'd0);
    add(0, 0, 4'h0, 0, 2'd0, 4'hF, 4'hF, 0,  0, 2'd0, 4'h0, 4'h2, 4'd0, 4'd0);
    for (int k = 0; k < 5; k++)
      add(0, 0, 4'h0, 0, 2'd0, 4'h0, 4'hF, 0,  1, 2'd1, 4'h0, 4'h2, 4'd0, 4'd1);
    add(0, 0, 4'h0, 0, 2'd0, 4'h0, 4'hF, 1,  1, 2'd1, 4'h2, 4'h2, 4'd0, 4'd1);
    add(0, 0, 4'h0, 0, 2'd0, 4'h0, 4'hF, 1,  0, 2'd0, 4'h0, 4'h2, 4'd1, 4'd1);
    add(0, 0, 4'h0, 0, 2'd0, 4'h0, 4'hF, 1,  0, 2'd0, 4'h0, 4'h2, 4'd1, 4'd2);
    // D: warp 3 held and retired without handshake -> valid drops, no pop
    add(1, 1, 4'h8, 0, 2'd0, 4'hF, 4'hF, 0,  0, 2'd0, 4'h0, 4'h0, 4'd0, 4'd0);
    add(0, 0, 4'h0, 0, 2'd0, 4'hF, 4'hF, 0,  0, 2'd0, 4'h0, 4'h8, 4'd0, 4'd0);
    add(0, 0, 4'h0, 1, 2'd3, 4'hF, 4'hF, 0,  1, 2'd3, 4'h0, 4'h8, 4'd0, 4'd1);
    add(0, 0, 4'h0, 0, 2'd0, 4'hF, 4'hF, 0,  0, 2'd0, 4'h0, 4'h0, 4'd0, 4'd1);
    add(0, 0, 4'h0, 0, 2'd0, 4'hF, 4'hF, 0,  0, 2'd0, 4'h0, 4'h0, 4'd0, 4'd1);
    // E: launch wins over retire, retire of inactive warp is a no-op
    add(1, 1, 4'h4, 0, 2'd0, 4'h0, 4'hF, 0,  0, 2'd0, 4'h0, 4'h0, 4'd0, 4'd0);
    add(0, 1, 4'h4, 1, 2'd2, 4'h0, 4'hF, 0,  0, 2'd0, 4'h0, 4'h4, 4'd0, 4'd0);
    add(0, 0, 4'h0, 1, 2'd0, 4'h0, 4'hF, 0,  0, 2'd0, 4'h0, 4'h4, 4'd0, 4'd1);
    add(0, 0, 4'h0, 1, 2'd2, 4'h0, 4'hF, 0,  0, 2'd0, 4'h0, 4'h4, 4'd0, 4'd2);
    add(0, 0, 4'h0, 0, 2'd0, 4'h0, 4'hF, 0,  0, 2'd0, 4'h0, 4'h0, 4'd0, 4'd3);
    // G: buf_valid gating (warps 1 and 3 only), cooldown forces an idle cycle
    add(1, 1, 4'hF, 0, 2'd0, 4'hF, 4'hA, 1,  0, 2'd0, 4'h0, 4'h0, 4'd0, 4'd0);
    add(0, 0, 4'h0, 0, 2'd0, 4'hF, 4'hA, 1,  0, 2'd0, 4'h0, 4'hF, 4'd0, 4'd0);
    add(0, 0, 4'h0, 0, 2'd0, 4'hF, 4'hA, 1,  1, 2'd1, 4'h2, 4'hF, 4'd0, 4'd1);
    add(0, 0, 4'h0, 0, 2'd0, 4'hF, 4'hA, 1,  1, 2'd3, 4'h8, 4'hF, 4'd1, 4'd1);
    add(0, 0, 4'h0, 0, 2'd0, 4'hF, 4'hA, 1,  0, 2'd0, 4'h0, 4'hF, 4'd2, 4'd1);
    add(0, 0, 4'h0, 0, 2'd0, 4'hF, 4'hA, 1,  1, 2'd1, 4'h2, 4'hF, 4'd2, 4'd2);

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.rst_before) do_reset($sformatf("v%0d", i));
      launch_valid = v.lv;
      launch_mask  = v.lm;
      retire_valid = v.rv;
      retire_id    = v.rid;
      ready_warps  = v.rdy;
      buf_valid    = v.bufv;
      issue_ready  = v.ir;
      #1;
      chk($sformatf("v%0d valid", i),  int'(issue_valid), int'(v.ev));
      if (v.ev) chk($sformatf("v%0d id", i), int'(issue_warp_id), int'(v.eid));
      chk($sformatf("v%0d grant", i),  int'(issue_grant), v.ev ? (1 << v.eid) : 0);
      chk($sformatf("v%0d pop", i),    int'(buf_pop), int'(v.epop));
      chk($sformatf("v%0d active", i), int'(active_warps), int'(v.eact));
      chk($sformatf("v%0d icnt", i),   int'(issue_count), int'(v.eicnt));
      chk($sformatf("v%0d stall", i),  int'(stall_count), int'(v.estall));
      @(posedge clk);
      #1;
    end

    // Saturation: 19 back-to-back handshakes on a 4-bit counter.
    do_reset("sat");
    launch_valid = 1'b1; launch_mask = 4'hF; retire_valid = 1'b0;
    ready_warps = 4'hF; buf_valid = 4'hF; issue_ready = 1'b1;
    @(posedge clk); #1;
    launch_valid = 1'b0; launch_mask = 4'h0;
    @(posedge clk); #1;
    for (int k = 0; k < 19; k++) begin
      exp_id  = k % 4;
      exp_cnt = (k > 15) ? 15 : k;
      #1;
      chk($sformatf("sat%0d valid", k), int'(issue_valid), 1);
      chk($sformatf("sat%0d id", k),    int'(issue_warp_id), exp_id);
      chk($sformatf("sat%0d pop", k),   int'(buf_pop), 1 << exp_id);
      chk($sformatf("sat%0d icnt", k),  int'(issue_count), exp_cnt);
      @(posedge clk); #1;
    end
    chk("sat final icnt", int'(issue_count), 15);
    chk("sat final valid", int'(issue_valid), 1);

    // Reset mid-HOLD: outputs return to reset values without waiting for a clock.
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst valid",  int'(issue_valid), 0);
    chk("midrst id",     int'(issue_warp_id), 0);
    chk("midrst grant",  int'(issue_grant), 0);
    chk("midrst pop",    int'(buf_pop), 0);
    chk("midrst active", int'(active_warps), 0);
    chk("midrst icnt",   int'(issue_count), 0);
    chk("midrst stall",  int'(stall_count), 0);
    @(posedge clk); #1;
    chk("midrst held valid", int'(issue_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
